// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access widths and controller states.
package load_store_unit_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_align.sv
// Lane steering for the load/store unit: byte enables, store-lane replication
// and load byte/half extraction with sign or zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  width,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and half word out of the returned word.
  always_comb begin
    byte_sel = load_word[7:0];
    case (offset)
      2'd1:    byte_sel = load_word[15:8];
      2'd2:    byte_sel = load_word[23:16];
      2'd3:    byte_sel = load_word[31:24];
      default: byte_sel = load_word[7:0];
    endcase
    half_sel = offset[1] ? load_word[31:16] : load_word[15:0];
  end

  // Width-dependent enables, store replication and load extension.
  always_comb begin
    be        = '0;
    wdata     = store_data;
    load_data = '0;
    case (width)
      WIDTH_BYTE: begin
        be        = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      WIDTH_HALF: begin
        be        = 4'b0011 << offset;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      end
      WIDTH_WORD: begin
        be        = 4'b1111;
        load_data = load_word;
      end
      default: begin
        be        = '0;
        load_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core access at a time, issues it to a
// grant/rvalid memory port, and returns a one-cycle completion pulse.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_width,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  import load_store_unit_pkg::*;

  lsu_state_e  state_q, state_d;
  logic [15:0] cnt_q;
  logic        we_q, unsigned_q, err_q;
  logic [1:0]  width_q;
  logic [31:0] addr_q, wdata_q, rdata_q;

  logic        bad_req, timeout_hit;
  logic [3:0]  align_be;
  logic [31:0] align_wdata, align_load;

  assign bad_req = (req_width == 2'd3) ||
                   ((req_width == WIDTH_HALF) && req_addr[0]) ||
                   ((req_width == WIDTH_WORD) && (req_addr[1:0] != 2'b00));

  // Counter starts at 0 on entry, so the limit is hit after TIMEOUT cycles.
  assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));

  lsu_align u_align (
    .width       (width_q),
    .is_unsigned (unsigned_q),
    .offset      (addr_q[1:0]),
    .store_data  (wdata_q),
    .load_word   (mem_rdata),
    .be          (align_be),
    .wdata       (align_wdata),
    .load_data   (align_load)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_be    = mem_req ? align_be : '0;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = align_wdata;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rdata_q;

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; grant and read data take priority over a timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = bad_req ? ST_RESP : ST_REQ;
      ST_REQ: begin
        if (mem_gnt)          state_d = we_q ? ST_RESP : ST_WAIT;
        else if (timeout_hit) state_d = ST_RESP;
      end
      ST_WAIT: if (mem_rvalid || timeout_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Captured request fields, wait counter and load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      width_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            unsigned_q <= req_unsigned;
            width_q    <= req_width;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            err_q      <= bad_req;
            rdata_q    <= '0;
            cnt_q      <= '0;
          end
        end
        ST_REQ: begin
          if (mem_gnt)          cnt_q <= '0;
          else if (timeout_hit) err_q <= 1'b1;
          else                  cnt_q <= cnt_q + 16'd1;
        end
        ST_WAIT: begin
          if (mem_rvalid)       rdata_q <= align_load;
          else if (timeout_hit) err_q   <= 1'b1;
          else                  cnt_q   <= cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a response scoreboard.
module tb_load_store_unit;

  localparam int unsigned TO = 255;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_width(req_width), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic send(input logic we, input logic [1:0] w, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
    req_we = we; req_width = w; req_unsigned = u; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_be, rsp_valid, rsp_err} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000000", {mem_req, mem_we, mem_be, rsp_valid, rsp_err});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: addr %h wdata %h rdata %h expected all 0", mem_addr, mem_wdata, rsp_rdata);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_byte;
    rsp_t e;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    send(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB);
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_be} !== 6'b11_1000 || mem_addr !== 32'h1000 ||
        mem_wdata !== 32'hABAB_ABAB || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL sb_request: req %b we %b be %b addr %h wdata %h rsp %b ready %b expected 1 1 1000 00001000 abababab 0 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, req_ready);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || mem_req !== 1'b0 || mem_be !== 4'h0) begin
      errors++; $display("FAIL sb_latency: rsp_valid %b mem_req %b be %b expected 1 0 0000 at T+2", rsp_valid, mem_req, mem_be);
    end else begin
      e = sb.pop_front();
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++; $display("FAIL sb_rsp: got %h/%b expected %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL sb_pulse: rsp_valid %b ready %b expected 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_loads;
    logic [31:0] t_addr  [6] = '{32'h2001, 32'h2001, 32'h2002, 32'h2002, 32'h2000, 32'h2003};
    logic [1:0]  t_width [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
    logic        t_uns   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_rd    [6] = '{32'h0000_8000, 32'h0000_8000, 32'h8001_1234,
                                 32'h8001_1234, 32'hDEAD_BEEF, 32'hA500_0000};
    logic [31:0] t_exp   [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                 32'h0000_8001, 32'hDEAD_BEEF, 32'h0000_00A5};
    logic [3:0]  t_be    [6] = '{4'b0010, 4'b0010, 4'b1100, 4'b1100, 4'b1111, 4'b1000};
    rsp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{rdata: t_exp[i], err: 1'b0});
      send(1'b0, t_width[i], t_uns[i], t_addr[i], 32'hFFFF_FFFF);
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== t_be[i] || mem_addr !== {t_addr[i][31:2], 2'b00}) begin
        errors++; $display("FAIL load%0d_req: req %b we %b be %b addr %h expected 1 0 %b %h",
                           i, mem_req, mem_we, mem_be, mem_addr, t_be[i], {t_addr[i][31:2], 2'b00});
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      checks++;
      if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL load%0d_wait: mem_req %b rsp_valid %b expected 0 0", i, mem_req, rsp_valid);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = t_rd[i];
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h5A5A_5A5A;
      checks++;
      if (rsp_valid !== 1'b1) begin
        errors++; $display("FAIL load%0d_latency: rsp_valid %b expected 1 at T+3", i, rsp_valid);
      end else begin
        e = sb.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
          errors++; $display("FAIL load%0d_rsp: got %h/%b expected %h/%b", i, rsp_rdata, rsp_err, e.rdata, e.err);
        end
      end
      @(negedge clk);
    end
    sb.delete();
  endtask

  task automatic test_misaligned;
    logic        t_we    [3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0]  t_width [3] = '{2'd1, 2'd3, 2'd2};
    logic [31:0] t_addr  [3] = '{32'h2003, 32'h2000, 32'h0102};
    rsp_t e;
    mem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{rdata: 32'h0, err: 1'b1});
      send(t_we[i], t_width[i], 1'b0, t_addr[i], 32'h1234_5678);
      checks++;
      if (mem_req !== 1'b0) begin
        errors++; $display("FAIL mis%0d_nomem: mem_req %b expected 0", i, mem_req);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || mem_req !== 1'b0) begin
        errors++; $display("FAIL mis%0d_latency: rsp_valid %b mem_req %b expected 1 0 at T+1", i, rsp_valid, mem_req);
      end else begin
        e = sb.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
          errors++; $display("FAIL mis%0d_rsp: got %h/%b expected %h/%b", i, rsp_rdata, rsp_err, e.rdata, e.err);
        end
      end
      @(negedge clk);
    end
    mem_gnt = 1'b0;
  endtask

  task automatic test_timeout;
    rsp_t e;
    int   n;
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    send(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (mem_req) n++;
      else break;
    end
    checks++;
    if (n != int'(TO)) begin
      errors++; $display("FAIL gnt_timeout_cycles: got %0d expected %0d", n, TO);
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL gnt_timeout_rsp: rsp_valid %b expected 1", rsp_valid);
    end else begin
      e = sb.pop_front();
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++; $display("FAIL gnt_timeout_data: got %h/%b expected %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL gnt_timeout_idle: ready %b expected 1", req_ready);
    end
    // Read data never returns after the grant.
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    send(1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    n = 1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!rsp_valid) n++;
      else break;
    end
    checks++;
    if (n != int'(TO) || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rvalid_timeout_cycles: got %0d valid %b expected %0d 1", n, rsp_valid, TO);
    end else begin
      e = sb.pop_front();
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++; $display("FAIL rvalid_timeout_data: got %h/%b expected %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    rsp_t e;
    logic seen;
    send(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_be, rsp_valid, rsp_err} !== 8'h00 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL midreset_outputs: ctrl %b addr %h wdata %h rdata %h expected all 0",
                         {mem_req, mem_we, mem_be, rsp_valid, rsp_err}, mem_addr, mem_wdata, rsp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midreset_norsp: rsp_valid seen %b expected 0", seen);
    end
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    send(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D);
    @(negedge clk);
    checks++;
    if (mem_be !== 4'b1111 || mem_addr !== 32'h10 || mem_wdata !== 32'hCAFE_F00D || mem_we !== 1'b1) begin
      errors++; $display("FAIL sw_after_reset: be %b addr %h wdata %h we %b expected 1111 00000010 cafef00d 1",
                         mem_be, mem_addr, mem_wdata, mem_we);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL sw_after_reset_rsp: rsp_valid %b expected 1", rsp_valid);
    end else begin
      e = sb.pop_front();
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++; $display("FAIL sw_after_reset_data: got %h/%b expected %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    rsp_t e;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    req_we = 1'b1; req_width = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h1234_5678; req_valid = 1'b1;
    @(posedge clk); #1;
    // Held req_valid with new fields must not disturb the access in flight.
    req_width = 2'd0; req_addr = 32'h33; req_wdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_be !== 4'b1100 || mem_wdata !== 32'h5678_5678) begin
        errors++; $display("FAIL sh_stable%0d: req %b addr %h be %b wdata %h expected 1 00000010 1100 56785678",
                           k, mem_req, mem_addr, mem_be, mem_wdata);
      end
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first_rsp: rsp_valid %b expected 1", rsp_valid);
    end else begin
      e = sb.pop_front();
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++; $display("FAIL b2b_first_data: got %h/%b expected %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h30 || mem_be !== 4'b1000 || mem_wdata !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL b2b_second_req: req %b addr %h be %b wdata %h expected 1 00000030 1000 ffffffff",
                         mem_req, mem_addr, mem_be, mem_wdata);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second_rsp: rsp_valid %b expected 1", rsp_valid);
    end else begin
      e = sb.pop_front();
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++; $display("FAIL b2b_second_data: got %h/%b expected %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_width = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_store_byte();
    test_loads();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent waiting for a memory grant or read data before the access aborts; legal range 1..65535.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  in  1  core presents an access.
REQ-005 req_ready  out  1  unit is in IDLE and can accept an access.
REQ-006 req_we  in  1  1 store, 0 load (MemRW).
REQ-007 req_width  in  2  0 byte, 1 half word, 2 word, 3 illegal (MEMBitWidth).
REQ-008 req_unsigned  in  1  load zero-extend when 1, sign-extend when 0 (MEMUnsigned).
REQ-009 req_addr  in  32  byte address (ALU result).
REQ-010 req_wdata  in  32  store data, right-justified (reg[rs2]).
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  out  1  qualifies rsp_valid: misaligned, illegal width or timeout.
REQ-014 mem_req, mem_we  out  1,1  memory request and write strobe.
REQ-015 mem_addr  out  32  word address: req_addr with bits [1:0] cleared.
REQ-016 mem_be  out  4  byte enables; mem_wdata  out  32  lane-shifted store data.
REQ-017 mem_gnt  in  1  memory accepts the request in the cycle mem_req=1.
REQ-018 mem_rvalid, mem_rdata  in  1, 32  load data return.

Function
REQ-019 States: IDLE, REQ, WAIT, RESP; req_ready=1 only in IDLE.
REQ-020 IDLE: on req_valid, all request fields are registered. A misaligned or illegal request goes to RESP with the error flag set. A legal request goes to REQ.
REQ-021 Misaligned: half word with addr[0]=1, or word with addr[1:0]!=0; no memory request is issued.
REQ-022 REQ: mem_req=1 with stable mem_addr/mem_we/mem_be/mem_wdata until mem_gnt. On grant, a store goes to RESP and a load goes to WAIT.
REQ-023 WAIT: capture mem_rdata on mem_rvalid, then go to RESP; mem_rvalid outside WAIT is ignored.
REQ-024 RESP: rsp_valid=1 for exactly one cycle, then IDLE; minimum latency is request accept at T to rsp_valid at T+2 (store, zero-wait grant) or T+3 (load, grant and rvalid each one cycle).
REQ-025 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; mem_be is 0 when mem_req=0.
REQ-026 Store lanes: byte data replicated to all four lanes; half data replicated to both halves; word data unchanged.
REQ-027 Load extract: select the byte or half at addr[1:0] from the word, then sign- or zero-extend per req_unsigned; word loads ignore req_unsigned.
REQ-028 A 16-bit cycle counter clears on entry to REQ and on entry to WAIT. On reaching TIMEOUT in REQ or WAIT, drop mem_req, go to RESP with rsp_err=1, and return rsp_rdata=0.
REQ-029 req_valid is ignored outside IDLE; mem_gnt is ignored when mem_req=0.

Reset
REQ-030 rst_n low forces IDLE, counter 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, and all captured registers to 0.
REQ-031 Reset mid-access abandons the access with no response; the first request after release is accepted normally.

Structure
REQ-032 The shared package holds width encodings (BYTE=0, HALF=1, WORD=2) and the state enum; the control decoder uses the same width constants.
REQ-033 One combinational sub-module, lsu_align, computes mem_be, mem_wdata and the extended load data from width, unsigned flag, addr[1:0] and the data inputs.

Verification
REQ-034 SB: addr 0x1003, wdata 0xAB, gnt at once -> mem_addr 0x1000, be 4'b1000, wdata 0xABABABAB, rsp_valid at T+2, err=0.
REQ-035 LB signed: addr 0x2001, rdata 0x0000_8000 -> rsp_rdata 0xFFFFFF80; the same with LBU -> 0x00000080.
REQ-036 LH at 0x2003 -> no mem_req, rsp_valid with err=1 at T+1; req_width=3 behaves the same.
REQ-037 LW: gnt held low for 255 cycles with TIMEOUT=255 -> mem_req drops, rsp_err=1, rsp_rdata=0, then IDLE.
REQ-038 rst_n pulsed low while in WAIT -> outputs at reset values, no rsp_valid; a following SW to 0x10 completes with be 4'b1111.
